// File: rtl/riscv_pkg.sv
// Shared core definitions: hazard FSM encoding and register index constants.
package riscv_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] X0 = 5'd0;

    typedef enum logic {
        HC_IDLE    = 1'b0,
        HC_MD_WAIT = 1'b1
    } hc_state_t;

endpackage

// File: rtl/hazard_md_watchdog.sv
// Muldiv occupancy counter with sticky timeout flag.
module hazard_md_watchdog #(
    parameter int MAX_CYCLES = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic done,
    output logic expired,
    output logic timeout
);

    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt;

    // A done pulse on the limit cycle still counts as a normal completion.
    assign expired = run && !done && (cnt >= CW'(MAX_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (start) begin
            cnt <= CW'(1);
        end else if (run) begin
            if (done || expired) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (expired) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for load-use, muldiv occupancy and branch squash.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_controller
    import riscv_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ID_rs1,
    input  logic [REG_AW-1:0] ID_rs2,
    input  logic              ID_uses_rs1,
    input  logic              ID_uses_rs2,
    input  logic [REG_AW-1:0] EX_rd,
    input  logic              EX_memread,
    input  logic              EX_muldiv,
    input  logic              branch_taken,
    input  logic              md_done,
    output logic              md_start,
    output logic              pc_stall,
    output logic              IF_ID_stall,
    output logic              IF_ID_flush,
    output logic              ID_EX_stall,
    output logic              ID_EX_flush,
    output logic              EX_MEM_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles,
`endif
    output logic              md_timeout
);

    hc_state_t state;
    hc_state_t state_nxt;
    logic      lu;
    logic      md_run;
    logic      md_expired;

    assign lu = EX_memread && (EX_rd != X0) &&
                ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                 (ID_uses_rs2 && (ID_rs2 == EX_rd)));

    assign md_run = (state == HC_MD_WAIT) && !rst;

    hazard_md_watchdog #(
        .MAX_CYCLES(MD_MAX_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .run    (md_run),
        .done   (md_done),
        .expired(md_expired),
        .timeout(md_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        md_start     = 1'b0;
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        if (!rst) begin
            unique case (state)
                HC_IDLE: begin
                    if (EX_muldiv) begin
                        md_start     = 1'b1;
                        pc_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_stall  = 1'b1;
                        EX_MEM_flush = 1'b1;
                        state_nxt    = HC_MD_WAIT;
                    end else if (branch_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (lu) begin
                        pc_stall    = 1'b1;
                        IF_ID_stall = 1'b1;
                        ID_EX_flush = 1'b1;
                    end
                end
                HC_MD_WAIT: begin
                    // EX is frozen here, so branch and load-use are moot.
                    if (md_done || md_expired) begin
                        state_nxt = HC_IDLE;
                    end else begin
                        pc_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_stall  = 1'b1;
                        EX_MEM_flush = 1'b1;
                    end
                end
                default: state_nxt = HC_IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (IF_ID_flush && (flush_cycles != 32'hFFFF_FFFF)) begin
                flush_cycles <= flush_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: vector table plus muldiv sequences.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_uses_rs1, ID_uses_rs2;
    logic       EX_memread, EX_muldiv, branch_taken, md_done;

    logic md_start, pc_stall, IF_ID_stall, IF_ID_flush;
    logic ID_EX_stall, ID_EX_flush, EX_MEM_flush, md_timeout;
    logic w_md_start, w_pc_stall, w_IF_ID_stall, w_IF_ID_flush;
    logic w_ID_EX_stall, w_ID_EX_flush, w_EX_MEM_flush, w_md_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles, w_stall_cycles, w_flush_cycles;
`endif

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd), .EX_memread(EX_memread),
        .EX_muldiv(EX_muldiv), .branch_taken(branch_taken),
        .md_done(md_done), .md_start(md_start),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall),
        .IF_ID_flush(IF_ID_flush), .ID_EX_stall(ID_EX_stall),
        .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
        .md_timeout(md_timeout)
    );

    hazard_controller #(.MD_MAX_CYCLES(8)) dut_w (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd), .EX_memread(EX_memread),
        .EX_muldiv(EX_muldiv), .branch_taken(branch_taken),
        .md_done(md_done), .md_start(w_md_start),
        .pc_stall(w_pc_stall), .IF_ID_stall(w_IF_ID_stall),
        .IF_ID_flush(w_IF_ID_flush), .ID_EX_stall(w_ID_EX_stall),
        .ID_EX_flush(w_ID_EX_flush), .EX_MEM_flush(w_EX_MEM_flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(w_stall_cycles), .flush_cycles(w_flush_cycles),
`endif
        .md_timeout(w_md_timeout)
    );

    // {md_start, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_flush}
    logic [6:0] obs, w_obs;
    assign obs = {md_start, pc_stall, IF_ID_stall, IF_ID_flush,
                  ID_EX_stall, ID_EX_flush, EX_MEM_flush};
    assign w_obs = {w_md_start, w_pc_stall, w_IF_ID_stall, w_IF_ID_flush,
                    w_ID_EX_stall, w_ID_EX_flush, w_EX_MEM_flush};

    localparam logic [6:0] V_0     = 7'b0000000;
    localparam logic [6:0] V_START = 7'b1110101;
    localparam logic [6:0] V_WAIT  = 7'b0110101;
    localparam logic [6:0] V_LU    = 7'b0110010;
    localparam logic [6:0] V_BR    = 7'b0001010;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[10];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, exp);
        end
    endtask

    task automatic idle_in();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; EX_rd = 5'd0;
        ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
        EX_memread = 1'b0; EX_muldiv = 1'b0;
        branch_taken = 1'b0; md_done = 1'b0;
    endtask

    task automatic lu_in();
        ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1;
        EX_rd = 5'd5; EX_memread = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        idle_in();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"lu_rs1",      5, 0, 5, 1, 0, 1, 0, V_LU};
        tbl[1] = '{"lu_noload",   5, 0, 5, 1, 0, 0, 0, V_0};
        tbl[2] = '{"lu_x0",       0, 0, 0, 1, 0, 1, 0, V_0};
        tbl[3] = '{"rs2_unused",  0, 7, 7, 0, 0, 1, 0, V_0};
        tbl[4] = '{"lu_rs2",      0, 7, 7, 0, 1, 1, 0, V_LU};
        tbl[5] = '{"br_over_lu",  5, 0, 5, 1, 0, 1, 1, V_BR};
        tbl[6] = '{"br_only",     1, 2, 3, 1, 1, 0, 1, V_BR};
        tbl[7] = '{"rs1_mismatch",4, 6, 5, 1, 1, 1, 0, V_0};
        tbl[8] = '{"lu_r31",     31, 3, 31, 1, 1, 1, 0, V_LU};
        tbl[9] = '{"lu_both_off", 9, 9, 9, 0, 0, 1, 0, V_0};

        rst = 1'b1;
        idle_in();
        cyc();
        lu_in();
        EX_muldiv = 1'b1;
        branch_taken = 1'b1;
        #1;
        chk("reset_outs", obs, V_0);
        cyc();
        chk1("reset_timeout", md_timeout, 1'b0);
        do_reset();

        foreach (tbl[i]) begin
            cyc();
            idle_in();
            ID_rs1 = tbl[i].rs1; ID_rs2 = tbl[i].rs2; EX_rd = tbl[i].rd;
            ID_uses_rs1 = tbl[i].u1; ID_uses_rs2 = tbl[i].u2;
            EX_memread = tbl[i].mr; branch_taken = tbl[i].br;
            #1;
            chk(tbl[i].name, obs, tbl[i].exp);
        end

        // Divide: start at 0, waiting 1..32, done at 33, idle at 34.
        do_reset();
        for (int c = 0; c <= 34; c++) begin
            cyc();
            idle_in();
            EX_muldiv = (c <= 33);
            md_done = (c == 33);
            branch_taken = (c == 10);
            if (c == 12) lu_in();
            #1;
            if (c == 0) chk("div_start", obs, V_START);
            else if (c <= 32) chk($sformatf("div_wait%0d", c), obs, V_WAIT);
            else chk($sformatf("div_end%0d", c), obs, V_0);
        end
        chk1("div_no_timeout", md_timeout, 1'b0);

        // Back-to-back muldiv, with md_done in the start cycle ignored.
        for (int c = 0; c <= 5; c++) begin
            cyc();
            idle_in();
            EX_muldiv = 1'b1;
            md_done = (c == 0) || (c == 2) || (c == 5);
            #1;
            case (c)
                0, 3: chk($sformatf("b2b_start%0d", c), obs, V_START);
                1, 4: chk($sformatf("b2b_wait%0d", c), obs, V_WAIT);
                default: chk($sformatf("b2b_exit%0d", c), obs, V_0);
            endcase
        end
        cyc();
        idle_in();
        #1;
        chk("b2b_idle", obs, V_0);

        // Watchdog on the 8-cycle instance.
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            cyc();
            idle_in();
            EX_muldiv = (c <= 8);
            #1;
            if (c == 0) chk("wd_start", w_obs, V_START);
            else if (c <= 7) chk($sformatf("wd_wait%0d", c), w_obs, V_WAIT);
            else chk($sformatf("wd_rel%0d", c), w_obs, V_0);
            if (c == 8) chk1("wd_flag_pre", w_md_timeout, 1'b0);
            if (c >= 9) chk1($sformatf("wd_flag%0d", c), w_md_timeout, 1'b1);
        end
        cyc();
        lu_in();
        #1;
        chk("wd_idle_lu", w_obs, V_LU);
        do_reset();
        chk1("wd_flag_cleared", w_md_timeout, 1'b0);

        // Reset in the middle of MD_WAIT, then a stray md_done.
        for (int c = 0; c <= 7; c++) begin
            cyc();
            idle_in();
            EX_muldiv = (c <= 5);
            rst = (c == 5);
            md_done = (c == 6);
            if (c == 7) lu_in();
            #1;
            if (c == 0) chk("rmid_start", obs, V_START);
            else if (c <= 4) chk($sformatf("rmid_wait%0d", c), obs, V_WAIT);
            else if (c <= 6) chk($sformatf("rmid_zero%0d", c), obs, V_0);
            else chk("rmid_idle_lu", obs, V_LU);
        end
        chk1("rmid_timeout", md_timeout, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_tb got timeout want finish");
        $fatal(1);
    end

endmodule
